// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 exception/interrupt controller: register numbers,
// exception codes, SR/Cause field positions and the handler vector.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int unsigned SR_IE_BIT    = 0;
  localparam int unsigned SR_EXL_BIT   = 1;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned CAUSE_BD_BIT = 31;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_EXC_LO = 2;

  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

endpackage

// File: rtl/cp0_if.sv
// Pipeline <-> CP0 signal bundle; master is the M-stage datapath, slave is cp0.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BDIn;
  logic        ExcReq;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, WE, PC, BDIn, ExcReq, ExcCode, HWInt, EXLClr,
    input  IntReq, EPCOut, DOut
  );

  modport slave (
    input  A1, A2, DIn, WE, PC, BDIn, ExcReq, ExcCode, HWInt, EXLClr,
    output IntReq, EPCOut, DOut
  );
endinterface

// File: rtl/cp0_int_arb.sv
// Combinational exception/interrupt arbitration: pending terms, request and the
// ExcCode to latch (interrupt beats a synchronous exception).
module cp0_int_arb
  import cp0_pkg::*;
(
  input  logic [5:0] ip,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic       exc_req,
  input  logic [4:0] exc_code,
  output logic       int_pend,
  output logic       exc_pend,
  output logic       int_req,
  output logic [4:0] sel_code
);

  always_comb begin
    int_pend = (|(ip & im)) & ie & ~exl;
    exc_pend = exc_req & ~exl;
    int_req  = int_pend | exc_pend;
    sel_code = int_pend ? EXC_INT : exc_code;
  end

endmodule

// File: rtl/cp0.sv
// CP0 register file (SR/Cause/EPC/PRId) with mfc0/mtc0 access and exception entry.
// Optional macro CP0_BD_EN: record branch-delay status and restart at the branch.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h4D49_5053
) (
  input  logic clk,
  input  logic reset,
  cp0_if.slave bus
);

`ifdef CP0_BD_EN
  localparam logic BD_ENABLE = 1'b1;
`else
  localparam logic BD_ENABLE = 1'b0;
`endif

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_pend;
  logic        exc_pend;
  logic        arb_req;
  logic [4:0]  sel_code;
  logic        bd_in;
  logic [31:0] epc_next;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  cp0_int_arb u_arb (
    .ip       (ip),
    .im       (im),
    .ie       (ie),
    .exl      (exl),
    .exc_req  (bus.ExcReq),
    .exc_code (bus.ExcCode),
    .int_pend (int_pend),
    .exc_pend (exc_pend),
    .int_req  (arb_req),
    .sel_code (sel_code)
  );

  assign bd_in    = bus.BDIn & BD_ENABLE;
  assign epc_next = bd_in ? (bus.PC - 32'd4) : bus.PC;

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= bus.HWInt;
      if (arb_req) begin
        exl      <= 1'b1;
        exc_code <= sel_code;
        bd       <= bd_in;
        epc      <= epc_next;
      end else begin
        if (bus.WE) begin
          case (bus.A2)
            REG_SR: begin
              im  <= bus.DIn[SR_IM_LO +: 6];
              exl <= bus.DIn[SR_EXL_BIT];
              ie  <= bus.DIn[SR_IE_BIT];
            end
            REG_EPC: epc <= {bus.DIn[31:2], 2'b00};
            default: ;
          endcase
        end
        // Placed after the mtc0 write so eret wins on SR.EXL when both occur.
        if (bus.EXLClr) exl <= 1'b0;
      end
    end
  end

  always_comb begin
    sr_val    = '0;
    sr_val[SR_IM_LO +: 6]  = im;
    sr_val[SR_EXL_BIT]     = exl;
    sr_val[SR_IE_BIT]      = ie;
    cause_val = '0;
    cause_val[CAUSE_BD_BIT]         = bd;
    cause_val[CAUSE_IP_LO +: 6]     = ip;
    cause_val[CAUSE_EXC_LO +: 5]    = exc_code;
  end

  always_comb begin
    case (bus.A1)
      REG_SR:    bus.DOut = sr_val;
      REG_CAUSE: bus.DOut = cause_val;
      REG_EPC:   bus.DOut = epc;
      REG_PRID:  bus.DOut = PRID;
      default:   bus.DOut = '0;
    endcase
  end

  // Reset dominates: no request may leak out while reset is held.
  assign bus.IntReq = arb_req & ~reset;
  assign bus.EPCOut = epc;

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0; expectations follow CP0_BD_EN if defined.
module tb_cp0;

  localparam logic [31:0] PRID_V = 32'h4D49_5053;

  logic clk;
  logic reset;
  int   vectors;
  int   errors;

  cp0_if bus ();

  cp0 #(.PRID(PRID_V)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.A1 = '0; bus.A2 = '0; bus.DIn = '0; bus.WE = 1'b0;
    bus.PC = '0; bus.BDIn = 1'b0; bus.ExcReq = 1'b0; bus.ExcCode = '0;
    bus.HWInt = '0; bus.EXLClr = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0]  addrs [4];
    logic [31:0] exps  [4];
    addrs = '{5'd15, 5'd12, 5'd13, 5'd14};
    exps  = '{PRID_V, 32'h0, 32'h0, 32'h0};
    reset = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      bus.A1 = addrs[i];
      #1;
      vectors++;
      if (bus.DOut !== exps[i]) begin
        errors++;
        $display("FAIL reset_dout a1=%0d got %h exp %h", addrs[i], bus.DOut, exps[i]);
      end
    end
    vectors++;
    if (bus.IntReq !== 1'b0) begin
      errors++; $display("FAIL reset_intreq got %b exp 0", bus.IntReq);
    end
    vectors++;
    if (bus.EPCOut !== 32'h0) begin
      errors++; $display("FAIL reset_epcout got %h exp 0", bus.EPCOut);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_interrupt();
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_FC01;
    bus.HWInt = 6'b000100; bus.PC = 32'h0000_2000;
    #1;
    vectors++;
    if (bus.IntReq !== 1'b0) begin
      errors++; $display("FAIL int_before_edge got %b exp 0", bus.IntReq);
    end
    step();
    bus.WE = 1'b0;
    #1;
    vectors++;
    if (bus.IntReq !== 1'b1) begin
      errors++; $display("FAIL int_next_cycle got %b exp 1", bus.IntReq);
    end
    step();
    bus.A1 = 5'd13; #1;
    vectors++;
    if (bus.DOut !== 32'h0000_1000) begin
      errors++; $display("FAIL int_cause got %h exp 00001000", bus.DOut);
    end
    bus.A1 = 5'd12; #1;
    vectors++;
    if (bus.DOut !== 32'h0000_FC03) begin
      errors++; $display("FAIL int_sr_exl got %h exp 0000fc03", bus.DOut);
    end
    vectors++;
    if (bus.EPCOut !== 32'h0000_2000) begin
      errors++; $display("FAIL int_epc got %h exp 00002000", bus.EPCOut);
    end
    vectors++;
    if (bus.IntReq !== 1'b0) begin
      errors++; $display("FAIL int_exl_masks got %b exp 0", bus.IntReq);
    end
    bus.HWInt = '0; bus.EXLClr = 1'b1;
    step();
    bus.EXLClr = 1'b0; #1;
    vectors++;
    if (bus.DOut !== 32'h0000_FC01) begin
      errors++; $display("FAIL int_eret_sr got %h exp 0000fc01", bus.DOut);
    end
  endtask

  task automatic test_exception();
    logic [31:0] exp_cause;
    logic [31:0] exp_epc;
`ifdef CP0_BD_EN
    exp_cause = 32'h8000_0030; exp_epc = 32'h0000_300C;
`else
    exp_cause = 32'h0000_0030; exp_epc = 32'h0000_3010;
`endif
    bus.ExcReq = 1'b1; bus.ExcCode = 5'd12; bus.PC = 32'h0000_3010; bus.BDIn = 1'b1;
    #1;
    vectors++;
    if (bus.IntReq !== 1'b1) begin
      errors++; $display("FAIL exc_zero_latency got %b exp 1", bus.IntReq);
    end
    step();
    bus.ExcReq = 1'b0; bus.BDIn = 1'b0; bus.ExcCode = '0;
    bus.A1 = 5'd13; #1;
    vectors++;
    if (bus.DOut !== exp_cause) begin
      errors++; $display("FAIL exc_cause got %h exp %h", bus.DOut, exp_cause);
    end
    vectors++;
    if (bus.EPCOut !== exp_epc) begin
      errors++; $display("FAIL exc_epc got %h exp %h", bus.EPCOut, exp_epc);
    end
    vectors++;
    if (bus.IntReq !== 1'b0) begin
      errors++; $display("FAIL exc_deassert got %b exp 0", bus.IntReq);
    end
    // Nested exception while EXL=1 must be ignored.
    bus.ExcReq = 1'b1; bus.ExcCode = 5'd4; bus.PC = 32'h0000_5000;
    #1;
    vectors++;
    if (bus.IntReq !== 1'b0) begin
      errors++; $display("FAIL exc_nested_req got %b exp 0", bus.IntReq);
    end
    step();
    bus.ExcReq = 1'b0; #1;
    vectors++;
    if (bus.EPCOut !== exp_epc) begin
      errors++; $display("FAIL exc_nested_epc got %h exp %h", bus.EPCOut, exp_epc);
    end
    vectors++;
    if (bus.DOut !== exp_cause) begin
      errors++; $display("FAIL exc_nested_cause got %h exp %h", bus.DOut, exp_cause);
    end
    bus.HWInt = 6'b000001; bus.EXLClr = 1'b1;
    step();
    bus.EXLClr = 1'b0; bus.PC = 32'h0000_6000; #1;
    vectors++;
    if (bus.IntReq !== 1'b1) begin
      errors++; $display("FAIL eret_pending_int got %b exp 1", bus.IntReq);
    end
    step();
    bus.HWInt = '0; #1;
    vectors++;
    if (bus.DOut !== 32'h0000_0400) begin
      errors++; $display("FAIL eret_int_cause got %h exp 00000400", bus.DOut);
    end
    vectors++;
    if (bus.EPCOut !== 32'h0000_6000) begin
      errors++; $display("FAIL eret_int_epc got %h exp 00006000", bus.EPCOut);
    end
    bus.EXLClr = 1'b1;
    step();
    bus.EXLClr = 1'b0;
  endtask

  task automatic test_priority();
    bus.HWInt = 6'b000010;
    step();
    #1;
    vectors++;
    if (bus.IntReq !== 1'b1) begin
      errors++; $display("FAIL prio_int_pending got %b exp 1", bus.IntReq);
    end
    bus.ExcReq = 1'b1; bus.ExcCode = 5'd10; bus.PC = 32'h0000_7000;
    bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h1234_5678;
    step();
    bus.ExcReq = 1'b0; bus.WE = 1'b0; bus.HWInt = '0; bus.A1 = 5'd13; #1;
    vectors++;
    if (bus.DOut !== 32'h0000_0800) begin
      errors++; $display("FAIL prio_cause got %h exp 00000800", bus.DOut);
    end
    vectors++;
    if (bus.EPCOut !== 32'h0000_7000) begin
      errors++; $display("FAIL prio_mtc0_dropped got %h exp 00007000", bus.EPCOut);
    end
    bus.EXLClr = 1'b1;
    step();
    bus.EXLClr = 1'b0;
  endtask

  task automatic test_mtc0();
    bus.A1 = 5'd14; bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3007;
    #1;
    vectors++;
    if (bus.DOut !== 32'h0000_7000) begin
      errors++; $display("FAIL mtc0_rdw_old got %h exp 00007000", bus.DOut);
    end
    step();
    #1;
    vectors++;
    if (bus.EPCOut !== 32'h0000_3004) begin
      errors++; $display("FAIL mtc0_epc_align got %h exp 00003004", bus.EPCOut);
    end
    bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
    step();
    bus.A1 = 5'd13; #1;
    vectors++;
    if (bus.DOut !== 32'h0000_0000) begin
      errors++; $display("FAIL mtc0_cause_ro got %h exp 00000000", bus.DOut);
    end
    bus.A2 = 5'd3;
    step();
    bus.A1 = 5'd3; #1;
    vectors++;
    if (bus.DOut !== 32'h0000_0000) begin
      errors++; $display("FAIL mtc0_other_reg got %h exp 00000000", bus.DOut);
    end
    bus.A2 = 5'd12;
    step();
    bus.A1 = 5'd12; #1;
    vectors++;
    if (bus.DOut !== 32'h0000_FC03) begin
      errors++; $display("FAIL mtc0_sr_mask got %h exp 0000fc03", bus.DOut);
    end
    bus.DIn = 32'h0000_FC03; bus.EXLClr = 1'b1;
    step();
    bus.WE = 1'b0; bus.EXLClr = 1'b0; #1;
    vectors++;
    if (bus.DOut !== 32'h0000_FC01) begin
      errors++; $display("FAIL mtc0_eret_override got %h exp 0000fc01", bus.DOut);
    end
  endtask

  task automatic test_reset_mid_handler();
    bus.ExcReq = 1'b1; bus.ExcCode = 5'd5; bus.PC = 32'h0000_8000;
    step();
    bus.ExcReq = 1'b0; bus.A1 = 5'd12; #1;
    vectors++;
    if (bus.DOut !== 32'h0000_FC03) begin
      errors++; $display("FAIL rst_pre_exl got %h exp 0000fc03", bus.DOut);
    end
    reset = 1'b1; bus.ExcReq = 1'b1; bus.HWInt = 6'h3F;
    bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'hFFFF_FFF0;
    #1;
    step();
    vectors++;
    if (bus.IntReq !== 1'b0) begin
      errors++; $display("FAIL rst_intreq got %b exp 0", bus.IntReq);
    end
    vectors++;
    if (bus.DOut !== 32'h0) begin
      errors++; $display("FAIL rst_sr got %h exp 0", bus.DOut);
    end
    bus.A1 = 5'd13; #1;
    vectors++;
    if (bus.DOut !== 32'h0) begin
      errors++; $display("FAIL rst_cause got %h exp 0", bus.DOut);
    end
    vectors++;
    if (bus.EPCOut !== 32'h0) begin
      errors++; $display("FAIL rst_epc got %h exp 0", bus.EPCOut);
    end
    bus.A1 = 5'd15; #1;
    vectors++;
    if (bus.DOut !== PRID_V) begin
      errors++; $display("FAIL rst_prid got %h exp %h", bus.DOut, PRID_V);
    end
    reset = 1'b0;
    clear_inputs();
    step();
    bus.A1 = 5'd13; #1;
    vectors++;
    if (bus.DOut !== 32'h0) begin
      errors++; $display("FAIL rst_after_cause got %h exp 0", bus.DOut);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    clear_inputs();
    test_reset();
    test_interrupt();
    test_exception();
    test_priority();
    test_mtc0();
    test_reset_mid_handler();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
